// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator.
// A clock prescaler produces a pixel tick, and pixel_x/pixel_y count the raster on that tick.
// Every output is a registered decode of the next-state counters, so all outputs
// change on the same edge with no relative skew.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HActEnd = 10'(H_ACTIVE);
  localparam logic [9:0] HFpEnd  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSynEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HMax    = 10'(HTotal - 1);
  localparam logic [9:0] VActEnd = 10'(V_ACTIVE);
  localparam logic [9:0] VFpEnd  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSynEnd = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VMax    = 10'(VTotal - 1);

  // Raster phase within a line (or within a frame for the vertical axis).
  typedef enum logic [1:0] {PhAct, PhFpo, PhSyn, PhBpo} phase_e;

  function automatic phase_e decode_phase(input logic [9:0] c, input logic [9:0] act_end,
                                          input logic [9:0] fp_end, input logic [9:0] syn_end);
    phase_e ph;
    if (c < act_end)      ph = PhAct;
    else if (c < fp_end)  ph = PhFpo;
    else if (c < syn_end) ph = PhSyn;
    else                  ph = PhBpo;
    return ph;
  endfunction

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            pix_tick_q, pix_tick_d;
  logic            video_on_q, video_on_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  phase_e          h_ph, v_ph;

  // Next-state counters and the output decode of those next-state values.
  always_comb begin
    div_d      = (div_q == DivMax) ? '0 : div_q + DivW'(1);
    pix_tick_d = (div_d == DivMax);
    x_d        = x_q;
    y_d        = y_q;
    if (pix_tick_q) begin
      if (x_q == HMax) begin
        x_d = '0;
        y_d = (y_q == VMax) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    h_ph          = decode_phase(x_d, HActEnd, HFpEnd, HSynEnd);
    v_ph          = decode_phase(y_d, VActEnd, VFpEnd, VSynEnd);
    video_on_d    = (h_ph == PhAct) && (v_ph == PhAct);
    hsync_d       = (h_ph == PhSyn) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_ph == PhSyn) ? SYNC_POL : ~SYNC_POL;
    // Pulses fire only on an actual advance, so leaving reset at (0,0) is silent.
    line_start_d  = pix_tick_q && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  // All state and registered outputs; async reset clears mid-frame without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_tick_q    <= 1'b0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_tick_q    <= pix_tick_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a shrunken raster with
// CLK_DIV=3, and CLK_DIV=1 with active-high syncs) compared every clock against an
// arithmetic raster model, with randomly placed asynchronous resets.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       d_tick, d_vid, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  // Small raster: H 16/2/3/4 (25), V 8/2/2/3 (15), CLK_DIV=3.
  logic       s_tick, s_vid, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  // CLK_DIV=1, SYNC_POL=1, default raster.
  logic       f_tick, f_vid, f_hs, f_vs, f_ls, f_fs;
  logic [9:0] f_x, f_y;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst), .pix_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .video_on(d_vid), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(rst), .pix_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .video_on(s_vid), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u_fast (
    .clk(clk), .reset(rst), .pix_tick(f_tick), .pixel_x(f_x), .pixel_y(f_y),
    .video_on(f_vid), .hsync(f_hs), .vsync(f_vs), .line_start(f_ls), .frame_start(f_fs)
  );

  logic [25:0] d_vec, s_vec, f_vec;
  assign d_vec = {d_tick, d_x, d_y, d_vid, d_hs, d_vs, d_ls, d_fs};
  assign s_vec = {s_tick, s_x, s_y, s_vid, s_hs, s_vs, s_ls, s_fs};
  assign f_vec = {f_tick, f_x, f_y, f_vid, f_hs, f_vs, f_ls, f_fs};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned k;  // clock edges since reset release

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Pixel ticks completed after edge k: the first tick strobe is visible after edge
  // CLK_DIV-1 (edge 1 when CLK_DIV=1), and the raster advances on the following edge.
  function automatic int unsigned ticks(input int unsigned kk, input int unsigned d);
    if (kk == 0) return 0;
    return kk / d - ((d == 1) ? 1 : 0);
  endfunction

  // Expected output vector after edge k, straight from the raster arithmetic.
  function automatic logic [25:0] model(input int unsigned kk, input int unsigned d,
      input int unsigned ha, input int unsigned hfp, input int unsigned hs,
      input int unsigned hbp, input int unsigned va, input int unsigned vfp,
      input int unsigned vs, input int unsigned vbp, input bit pol);
    int unsigned ht, vt, n, x, y;
    logic tick, adv, vid, hsy, vsy, ls, fs;
    if (kk == 0) return {1'b0, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0};
    ht   = ha + hfp + hs + hbp;
    vt   = va + vfp + vs + vbp;
    n    = ticks(kk, d);
    adv  = (n != ticks(kk - 1, d));
    x    = n % ht;
    y    = (n / ht) % vt;
    tick = ((kk % d) == d - 1);
    vid  = (x < ha) && (y < va);
    hsy  = (x >= ha + hfp && x < ha + hfp + hs) ? pol : ~pol;
    vsy  = (y >= va + vfp && y < va + vfp + vs) ? pol : ~pol;
    ls   = adv && (x == 0);
    fs   = ls && (y == 0);
    return {tick, 10'(x), 10'(y), vid, hsy, vsy, ls, fs};
  endfunction

  task automatic compare_all(input string sfx);
    check_eq({"def", sfx},   32'(d_vec), 32'(model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
    check_eq({"small", sfx}, 32'(s_vec), 32'(model(k, 3, 16, 2, 3, 4, 8, 2, 2, 3, 1'b0)));
    check_eq({"fast", sfx},  32'(f_vec), 32'(model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1)));
  endtask

  // Directed timing measurements, taken in the first segment after power-up reset.
  int d_hs_on = -1, d_hs_off = -1, d_ls1 = -1, d_ls2 = -1;
  int f_hs_on = -1, f_hs_off = -1, f_ls1 = -1, f_ls2 = -1, f_tick_low = 0;
  int s_fs1 = -1, s_fs2 = -1, s_vs_on = -1, s_vs_off = -1;
  int unsigned s_vs_x = 0, s_vs_y = 0, s_max_x = 0, s_max_y = 0;
  logic d_hs_p, f_hs_p, s_vs_p;
  logic [9:0] s_x_p, s_y_p;

  task automatic clear_prev();
    d_hs_p = 1'b1;
    f_hs_p = 1'b0;
    s_vs_p = 1'b1;
    s_x_p  = '0;
    s_y_p  = '0;
  endtask

  task automatic run_cycles(input int unsigned n, input bit measure);
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      compare_all("");
      if (measure) begin
        if (!d_hs && d_hs_p && d_hs_on < 0) d_hs_on = int'(k);
        if (d_hs && !d_hs_p && d_hs_off < 0) d_hs_off = int'(k);
        if (d_ls) begin
          if (d_ls1 < 0) d_ls1 = int'(k);
          else if (d_ls2 < 0) d_ls2 = int'(k);
        end
        if (f_hs && !f_hs_p && f_hs_on < 0) f_hs_on = int'(k);
        if (!f_hs && f_hs_p && f_hs_off < 0) f_hs_off = int'(k);
        if (f_ls) begin
          if (f_ls1 < 0) f_ls1 = int'(k);
          else if (f_ls2 < 0) f_ls2 = int'(k);
        end
        if (f_tick !== 1'b1) f_tick_low++;
        if (s_fs) begin
          if (s_fs1 < 0) s_fs1 = int'(k);
          else if (s_fs2 < 0) s_fs2 = int'(k);
        end
        if (!s_vs && s_vs_p && s_vs_on < 0) begin
          s_vs_on = int'(k);
          s_vs_x  = s_x;
          s_vs_y  = s_y;
        end
        if (s_vs && !s_vs_p && s_vs_off < 0) s_vs_off = int'(k);
      end
      if (s_x > s_max_x) s_max_x = s_x;
      if (s_y > s_max_y) s_max_y = s_y;
      // The tick after (24,14) must land on (0,0) with frame_start.
      if (s_fs) check_eq("small_wrap_from", {12'd0, s_x_p, s_y_p}, {12'd0, 10'd24, 10'd14});
      d_hs_p = d_hs;
      f_hs_p = f_hs;
      s_vs_p = s_vs;
      s_x_p  = s_x;
      s_y_p  = s_y;
    end
  endtask

  // Async reset asserted between edges; outputs must clear before the next edge.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    k = 0;
    compare_all("_async_rst");
    @(posedge clk);
    @(negedge clk);
    compare_all("_in_rst");
    rst = 1'b0;
    clear_prev();
  endtask

  initial begin
    rst = 1'b1;
    k   = 0;
    clear_prev();
    repeat (3) @(negedge clk);
    compare_all("_por");
    rst = 1'b0;

    run_cycles(3500, 1'b1);
    check_eq("def_first_hsync_clk", d_hs_on, 1312);
    check_eq("def_hsync_width", d_hs_off - d_hs_on, 192);
    check_eq("def_line_period", d_ls2 - d_ls1, 1600);
    check_eq("fast_hsync_width", f_hs_off - f_hs_on, 96);
    check_eq("fast_line_period", f_ls2 - f_ls1, 800);
    check_eq("fast_tick_low_clks", f_tick_low, 0);
    check_eq("small_frame_period", s_fs2 - s_fs1, 1125);
    check_eq("small_vsync_width", s_vs_off - s_vs_on, 150);
    check_eq("small_vsync_start_xy", {12'd0, 10'(s_vs_x), 10'(s_vs_y)}, {12'd0, 10'd0, 10'd10});

    repeat (4) begin
      run_cycles($urandom_range(100, 2500), 1'b0);
      apply_reset();
    end
    run_cycles(1500, 1'b0);

    check_eq("small_max_x", s_max_x, 24);
    check_eq("small_max_y", s_max_y, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
